// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM access sequencer.
package sram_seq_pkg;

    // Access sequence states; every granted access walks a fixed path through these.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } seq_state_t;

    // Requester identities as carried on gnt_id and the round-robin pointer.
    localparam logic REQ_B = 1'b0;
    localparam logic REQ_C = 1'b1;

    // Default SRAM map: key word at the bottom, data region above it.
    localparam logic [15:0] KEY_ADDR_DEF  = 16'd0;
    localparam logic [15:0] DATA_ADDR_DEF = 16'd32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the bus (B) and core (C) requesters.
module rr_arb2
    import sram_seq_pkg::*;
(
    input  logic i_req_b,
    input  logic i_req_c,
    input  logic i_last,
    output logic o_valid,
    output logic o_win
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        o_valid = i_req_b | i_req_c;
        o_win   = REQ_B;
        if (i_req_b && i_req_c) begin
            o_win = ~i_last;
        end else if (i_req_c) begin
            o_win = REQ_C;
        end
    end

endmodule

// File: rtl/sram_access_sequencer.sv
// Arbitrates the bus and core requesters onto the shared key/data SRAM and
// runs each granted access as setup / strobe / wait / respond.
//
// Handshake: a requester raises req with stable we/addr/wdata and holds it
// until it sees its one-cycle ack; it drops req in the following cycle. The
// request fields are only looked at in IDLE and are latched at the grant edge,
// so later input changes never affect an access in flight. A req still high
// in the IDLE after its ack is treated as a fresh request.
module sram_access_sequencer
    import sram_seq_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 128,
    parameter int                RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] KEY_ADDR = ADDR_W'(KEY_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              key_lock,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              gnt_id,
    output seq_state_t        dbg_state
);

    seq_state_t        r_state;
    logic              r_last;
    logic              r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_cnt;
    logic              r_b_ack;
    logic              r_b_err;
    logic              r_c_ack;
    logic [DATA_W-1:0] r_b_rdata;
    logic [DATA_W-1:0] r_c_rdata;

    logic              w_valid;
    logic              w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_reject;

    rr_arb2 u_arb (
        .i_req_b (b_req),
        .i_req_c (c_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_win   (w_win)
    );

    // Select the winner's request fields and flag a forbidden bus key write.
    always_comb begin
        w_win_we    = (w_win == REQ_C) ? c_we    : b_we;
        w_win_addr  = (w_win == REQ_C) ? c_addr  : b_addr;
        w_win_wdata = (w_win == REQ_C) ? c_wdata : b_wdata;
        w_reject    = (w_win == REQ_B) && b_we && (b_addr == KEY_ADDR) && key_lock;
    end

    // Access sequencer: grant, latch, strobe, wait out read latency, respond.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_last    <= REQ_C;
            r_gnt     <= REQ_B;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_c_ack   <= 1'b0;
            r_b_rdata <= '0;
            r_c_rdata <= '0;
        end else begin
            r_b_ack <= 1'b0;
            r_b_err <= 1'b0;
            r_c_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= w_win;
                        r_last  <= w_win;
                        r_we    <= w_win_we;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        if (w_reject) begin
                            r_state <= ERR;
                            r_b_ack <= 1'b1;
                            r_b_err <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    r_cnt <= '0;
                    if (r_we) begin
                        r_state <= RESP;
                        r_b_ack <= (r_gnt == REQ_B);
                        r_c_ack <= (r_gnt == REQ_C);
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'(RD_LAT - 1)) begin
                        r_state <= RESP;
                        r_b_ack <= (r_gnt == REQ_B);
                        r_c_ack <= (r_gnt == REQ_C);
                        if (r_gnt == REQ_C) begin
                            r_c_rdata <= read_data;
                        end else begin
                            r_b_rdata <= read_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // SRAM pins follow the state directly so a reset drops them at once.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        addr       = '0;
        write_data = '0;
        case (r_state)
            SETUP: begin
                addr = r_addr;
                if (r_we) write_data = r_wdata;
            end
            ACCESS: begin
                addr = r_addr;
                if (r_we) begin
                    write_data = r_wdata;
                    write      = 1'b1;
                end else begin
                    read = 1'b1;
                end
            end
            WAIT: begin
                addr = r_addr;
            end
            default: ;
        endcase
    end

    assign b_ack     = r_b_ack;
    assign b_err     = r_b_err;
    assign c_ack     = r_c_ack;
    assign b_rdata   = r_b_rdata;
    assign c_rdata   = r_c_rdata;
    assign busy      = (r_state != IDLE);
    assign gnt_id    = r_gnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a small SRAM model (RD_LAT=3).
module tb_sram_access_sequencer;
  import sram_seq_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  localparam int RD_LAT = 3;

  localparam logic [DATA_W-1:0] V_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] V_CW = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DATA_W-1:0] V_FF = {16{8'hFF}};
  localparam logic [DATA_W-1:0] V_3C = {16{8'h3C}};
  localparam logic [DATA_W-1:0] V_5A = {16{8'h5A}};
  localparam logic [DATA_W-1:0] V_11 = {16{8'h11}};
  localparam logic [DATA_W-1:0] V_22 = {16{8'h22}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_ack, b_err;
  logic [DATA_W-1:0] b_rdata;
  logic              c_req = 1'b0, c_we = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;
  logic              key_lock = 1'b0;
  logic              read, write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data, read_data;
  logic              busy, gnt_id;
  seq_state_t        dbg_state;

  sram_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .KEY_ADDR(16'd0)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .key_lock(key_lock),
    .read(read), .write(write), .addr(addr), .write_data(write_data),
    .read_data(read_data),
    .busy(busy), .gnt_id(gnt_id), .dbg_state(dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [DATA_W-1:0] mem  [0:63];
  logic [DATA_W-1:0] pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (write) mem[addr[5:0]] <= write_data;
    pipe[0] <= read ? mem[addr[5:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign read_data = pipe[RD_LAT-1];

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;

  int                wr_cyc, rd_cyc, back_cyc, cack_cyc, strobes;
  logic              err_seen, g1;
  logic [ADDR_W-1:0] wr_addr, a1, a2;
  logic [DATA_W-1:0] wr_data;

  // Monitor one access cycle by cycle (cycle 0 = grant IDLE cycle), sampling at
  // negedge; returns at posedge+1 of the cycle after the ack.
  task automatic observe(input int start, input bit drop);
    int cyc;
    bit done;
    wr_cyc = -1; rd_cyc = -1; back_cyc = -1; cack_cyc = -1; strobes = 0;
    err_seen = 1'b0; g1 = 1'b0; wr_addr = '0; a1 = '0; a2 = '0; wr_data = '0;
    done = 1'b0;
    cyc = start;
    while (!done && cyc < 30) begin
      @(negedge clk);
      if (write) begin
        strobes++;
        if (wr_cyc < 0) begin wr_cyc = cyc; wr_addr = addr; wr_data = write_data; end
      end
      if (read) begin
        strobes++;
        if (rd_cyc < 0) rd_cyc = cyc;
      end
      if (cyc == 1) begin a1 = addr; g1 = gnt_id; end
      if (cyc == 2) a2 = addr;
      if (b_ack) begin back_cyc = cyc; err_seen = b_err; done = 1'b1; end
      if (c_ack) begin cack_cyc = cyc; done = 1'b1; end
      if (done && drop) begin b_req = 1'b0; c_req = 1'b0; end
      cyc++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL ack_timeout: got no ack by cycle %0d, required an ack", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic hold_reset();
    n_rst = 1'b0;
    b_req = 1'b0; c_req = 1'b0; key_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hold_reset();
    total++;
    if ({read, write, addr, write_data} !== '0) begin
      bad++; $display("FAIL reset_sram_pins: got rd=%b wr=%b addr=%h, required all 0", read, write, addr);
    end
    total++;
    if ({b_ack, b_err, c_ack, busy, gnt_id} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b, required 00000", {b_ack, b_err, c_ack, busy, gnt_id});
    end
    total++;
    if ({b_rdata, c_rdata} !== '0) begin
      bad++; $display("FAIL reset_rdata: got b=%h c=%h, required 0", b_rdata, c_rdata);
    end
    release_reset();
  endtask

  task automatic test_bus_write();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd32; b_wdata = V_A5;
    observe(0, 1'b1);
    total++;
    if (wr_cyc !== 2) begin bad++; $display("FAIL bw_strobe_cycle: got %0d required 2", wr_cyc); end
    total++;
    if (wr_addr !== 16'd32) begin bad++; $display("FAIL bw_addr: got %0d required 32", wr_addr); end
    total++;
    if (wr_data !== V_A5) begin bad++; $display("FAIL bw_data: got %h required %h", wr_data, V_A5); end
    total++;
    if (back_cyc !== 3) begin bad++; $display("FAIL bw_ack_cycle: got %0d required 3", back_cyc); end
    total++;
    if (cack_cyc !== -1 || err_seen !== 1'b0) begin
      bad++; $display("FAIL bw_no_cack_err: got cack=%0d err=%b required -1/0", cack_cyc, err_seen);
    end
    total++;
    if (strobes !== 1) begin bad++; $display("FAIL bw_strobes: got %0d required 1", strobes); end
    total++;
    if (mem[32] !== V_A5) begin bad++; $display("FAIL bw_mem: got %h required %h", mem[32], V_A5); end
  endtask

  task automatic test_bus_read();
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'd32;
    observe(0, 1'b1);
    total++;
    if (rd_cyc !== 2 || a2 !== 16'd32) begin
      bad++; $display("FAIL br_strobe: got cyc=%0d addr=%0d required 2/32", rd_cyc, a2);
    end
    total++;
    if (back_cyc !== 3 + RD_LAT) begin bad++; $display("FAIL br_ack_cycle: got %0d required %0d", back_cyc, 3 + RD_LAT); end
    total++;
    if (b_rdata !== V_A5) begin bad++; $display("FAIL br_rdata: got %h required %h", b_rdata, V_A5); end
  endtask

  task automatic test_core_write();
    key_lock = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'd0; c_wdata = V_CW;
    observe(0, 1'b1);
    key_lock = 1'b0;
    total++;
    if (cack_cyc !== 3 || back_cyc !== -1) begin
      bad++; $display("FAIL cw_ack: got cack=%0d back=%0d required 3/-1", cack_cyc, back_cyc);
    end
    total++;
    if (mem[0] !== V_CW) begin bad++; $display("FAIL cw_mem: got %h required %h", mem[0], V_CW); end
  endtask

  task automatic test_core_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd0;
    observe(0, 1'b1);
    total++;
    if (rd_cyc !== 2 || g1 !== 1'b1) begin
      bad++; $display("FAIL cr_strobe: got cyc=%0d gnt=%b required 2/1", rd_cyc, g1);
    end
    total++;
    if (cack_cyc !== 6) begin bad++; $display("FAIL cr_ack_cycle: got %0d required 6", cack_cyc); end
    total++;
    if (c_rdata !== V_CW) begin bad++; $display("FAIL cr_rdata: got %h required %h", c_rdata, V_CW); end
    total++;
    if (b_rdata !== V_A5) begin bad++; $display("FAIL cr_b_rdata_hold: got %h required %h", b_rdata, V_A5); end
  endtask

  task automatic test_key_lock();
    key_lock = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd0; b_wdata = V_FF;
    observe(0, 1'b1);
    total++;
    if (back_cyc !== 1 || err_seen !== 1'b1) begin
      bad++; $display("FAIL kl_reject: got ack_cyc=%0d err=%b required 1/1", back_cyc, err_seen);
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL kl_no_strobe: got %0d required 0", strobes); end
    total++;
    if (mem[0] !== V_CW) begin bad++; $display("FAIL kl_mem_kept: got %h required %h", mem[0], V_CW); end
    // unlocked at grant; raising the lock mid-access must not matter
    key_lock = 1'b0;
    b_req = 1'b1; b_wdata = V_3C;
    @(posedge clk); #1;
    key_lock = 1'b1;
    observe(1, 1'b1);
    key_lock = 1'b0;
    total++;
    if (back_cyc !== 3 || err_seen !== 1'b0) begin
      bad++; $display("FAIL kl_unlocked: got ack_cyc=%0d err=%b required 3/0", back_cyc, err_seen);
    end
    total++;
    if (mem[0] !== V_3C) begin bad++; $display("FAIL kl_mem_written: got %h required %h", mem[0], V_3C); end
  endtask

  task automatic test_addr_change();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd32; b_wdata = V_5A;
    @(posedge clk); #1;
    b_addr = 16'd0; b_wdata = '1;
    observe(1, 1'b1);
    total++;
    if (a1 !== 16'd32 || a2 !== 16'd32 || wr_addr !== 16'd32) begin
      bad++; $display("FAIL ac_addr: got %0d/%0d/%0d required 32", a1, a2, wr_addr);
    end
    total++;
    if (wr_data !== V_5A || mem[32] !== V_5A) begin
      bad++; $display("FAIL ac_data: got strobe=%h mem=%h required %h", wr_data, mem[32], V_5A);
    end
    total++;
    if (mem[0] !== V_3C) begin bad++; $display("FAIL ac_key_kept: got %h required %h", mem[0], V_3C); end
  endtask

  task automatic test_round_robin();
    hold_reset();
    release_reset();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd40; b_wdata = V_11;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'd48; c_wdata = V_22;
    for (int n = 0; n < 4; n++) begin
      logic exp_c;
      exp_c = (n % 2) == 1;
      observe(0, n == 3);
      total++;
      if (g1 !== exp_c) begin bad++; $display("FAIL rr_gnt_%0d: got %b required %b", n, g1, exp_c); end
      total++;
      if ((exp_c ? cack_cyc : back_cyc) !== 3) begin
        bad++; $display("FAIL rr_ack_%0d: got back=%0d cack=%0d required owner ack at 3", n, back_cyc, cack_cyc);
      end
    end
    total++;
    if (mem[40] !== V_11 || mem[48] !== V_22) begin
      bad++; $display("FAIL rr_mem: got %h/%h required %h/%h", mem[40], mem[48], V_11, V_22);
    end
  endtask

  task automatic test_reset_mid_read();
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'd32;
    repeat (4) @(negedge clk);
    total++;
    if (dbg_state !== WAIT || addr !== 16'd32) begin
      bad++; $display("FAIL rm_in_wait: got state=%0d addr=%0d required WAIT/32", dbg_state, addr);
    end
    n_rst = 1'b0;
    #1;
    total++;
    if ({read, write, b_ack, c_ack, busy} !== 5'b0 || addr !== '0) begin
      bad++; $display("FAIL rm_async_drop: got rd=%b ack=%b/%b busy=%b addr=%0d required 0", read, b_ack, c_ack, busy, addr);
    end
    total++;
    if (b_rdata !== '0) begin bad++; $display("FAIL rm_rdata_clear: got %h required 0", b_rdata); end
    b_req = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd40; b_wdata = V_5A;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'd48; c_wdata = V_5A;
    observe(0, 1'b1);
    total++;
    if (g1 !== 1'b0 || back_cyc !== 3 || cack_cyc !== -1) begin
      bad++; $display("FAIL rm_tie_after_reset: got gnt=%b back=%0d cack=%0d required 0/3/-1", g1, back_cyc, cack_cyc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_bus_write();
    test_bus_read();
    test_core_write();
    test_core_read();
    test_key_lock();
    test_addr_change();
    test_round_robin();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
